// File: rtl/width_up_conv.sv
// Narrow-to-wide stream packer: gathers RATIO beats of IN_W bits into one registered word,
// with keep/last sideband. Build macro WIDTH_UP_CONV_ZERO_PAD_EN zeroes unfilled lanes.
module width_up_conv #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [IN_W-1:0]       data_in,
    input  logic                  last_in,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [IN_W*RATIO-1:0] data_out,
    output logic [RATIO-1:0]      keep_out,
    output logic                  last_out
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = (RATIO <= 2) ? 1 : $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_acc;
    logic [RATIO-1:0] r_acc_keep;
    logic             r_valid_out;
    logic [OUT_W-1:0] r_data_out;
    logic [RATIO-1:0] r_keep_out;
    logic             r_last_out;

    logic             w_ready_in;
    logic             w_accept;
    logic             w_complete;
    logic [CNT_W-1:0] w_lane;
    logic [OUT_W-1:0] w_acc_next;
    logic [RATIO-1:0] w_keep_next;

    // An input beat can move whenever the output register is empty or being drained this cycle.
    assign w_ready_in = !r_valid_out || ready_out;
    assign w_accept   = valid_in && w_ready_in;
    assign w_complete = w_accept && ((r_cnt == LAST_CNT) || last_in);
    assign w_lane     = (MSB_FIRST != 0) ? (LAST_CNT - r_cnt) : r_cnt;

    always_comb begin
        w_acc_next  = r_acc;
        w_keep_next = r_acc_keep;
        for (int i = 0; i < RATIO; i++) begin
            if (CNT_W'(i) == w_lane) begin
                w_acc_next[i*IN_W +: IN_W] = data_in;
                w_keep_next[i]             = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_acc_keep <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_cnt      <= '0;
                r_acc_keep <= '0;
`ifdef WIDTH_UP_CONV_ZERO_PAD_EN
                r_acc      <= '0;
`else
                // Stale lanes are left in place; keep_out tells the consumer which lanes are real.
                r_acc      <= w_acc_next;
`endif
            end else begin
                r_cnt      <= r_cnt + CNT_W'(1);
                r_acc      <= w_acc_next;
                r_acc_keep <= w_keep_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_keep_out  <= '0;
            r_last_out  <= 1'b0;
        end else if (w_complete) begin
            r_valid_out <= 1'b1;
            r_data_out  <= w_acc_next;
            r_keep_out  <= w_keep_next;
            r_last_out  <= last_in;
        end else if (ready_out) begin
            r_valid_out <= 1'b0;
        end
    end

    assign ready_in  = w_ready_in;
    assign valid_out = r_valid_out;
    assign data_out  = r_data_out;
    assign keep_out  = r_keep_out;
    assign last_out  = r_last_out;

endmodule

// File: tb/tb_width_up_conv.sv
// Bench for width_up_conv: one MSB-first and one LSB-first instance share the same stimulus;
// a beat-level model fills per-instance expected queues that the output monitor drains.
module tb_width_up_conv;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;
  localparam int E_W   = OUT_W + RATIO + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             valid_in;
  logic [IN_W-1:0]  data_in;
  logic             last_in;
  logic             ready_out;

  logic             ready_in_m, valid_out_m, last_out_m;
  logic [OUT_W-1:0] data_out_m;
  logic [RATIO-1:0] keep_out_m;
  logic             ready_in_l, valid_out_l, last_out_l;
  logic [OUT_W-1:0] data_out_l;
  logic [RATIO-1:0] keep_out_l;

  width_up_conv #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in_m),
    .data_in(data_in), .last_in(last_in), .valid_out(valid_out_m),
    .ready_out(ready_out), .data_out(data_out_m), .keep_out(keep_out_m),
    .last_out(last_out_m)
  );

  width_up_conv #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in_l),
    .data_in(data_in), .last_in(last_in), .valid_out(valid_out_l),
    .ready_out(ready_out), .data_out(data_out_l), .keep_out(keep_out_l),
    .last_out(last_out_l)
  );

  // scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  logic [E_W-1:0] exp_q_m[$];
  logic [E_W-1:0] exp_q_l[$];

  int               m_cnt;
  logic [OUT_W-1:0] m_data_m, m_data_l;
  logic [RATIO-1:0] m_keep_m, m_keep_l;

  bit bp_arm  = 1'b0;
  bit rand_bp = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] lane_mask(input logic [RATIO-1:0] k);
    logic [OUT_W-1:0] m;
    m = '0;
    for (int i = 0; i < RATIO; i++) m[i*IN_W +: IN_W] = {IN_W{k[i]}};
    return m;
  endfunction

  task automatic cmp_word(input string tag, input logic [E_W-1:0] got, input logic [E_W-1:0] exp);
    logic [OUT_W-1:0] msk;
    msk = lane_mask(exp[OUT_W +: RATIO]);
    check_val({tag, "_keep"}, 64'(got[OUT_W +: RATIO]), 64'(exp[OUT_W +: RATIO]));
    check_val({tag, "_last"}, 64'(got[E_W-1]), 64'(exp[E_W-1]));
    check_val({tag, "_data"}, 64'(got[OUT_W-1:0] & msk), 64'(exp[OUT_W-1:0] & msk));
`ifdef WIDTH_UP_CONV_ZERO_PAD_EN
    check_val({tag, "_pad"}, 64'(got[OUT_W-1:0]), 64'(exp[OUT_W-1:0]));
`endif
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_data_m = '0;
    m_data_l = '0;
    m_keep_m = '0;
    m_keep_l = '0;
  endtask

  task automatic model_beat(input logic [IN_W-1:0] d, input logic last, output bit done);
    m_data_m[(RATIO-1-m_cnt)*IN_W +: IN_W] = d;
    m_keep_m[RATIO-1-m_cnt]                = 1'b1;
    m_data_l[m_cnt*IN_W +: IN_W]           = d;
    m_keep_l[m_cnt]                        = 1'b1;
    done = (m_cnt == RATIO-1) || last;
    if (done) begin
      exp_q_m.push_back({last, m_keep_m, m_data_m});
      exp_q_l.push_back({last, m_keep_l, m_data_l});
      model_reset();
    end else begin
      m_cnt++;
    end
  endtask

  // driver tasks
  task automatic send_beat(input logic [IN_W-1:0] d, input logic last);
    int waited;
    bit done;
    waited   = 0;
    valid_in = 1'b1;
    data_in  = d;
    last_in  = last;
    while (!ready_in_m && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_in_m) begin
      check_val("accept_timeout", 64'(0), 64'(1));
      valid_in = 1'b0;
      return;
    end
    model_beat(d, last, done);
    @(negedge clk);
    if (done) begin
      check_val("latency_msb", 64'(valid_out_m), 64'(1));
      check_val("latency_lsb", 64'(valid_out_l), 64'(1));
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    data_in  = IN_W'($urandom);
    last_in  = 1'($urandom_range(0, 1));
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, 64'(valid_out_m | valid_out_l), 64'(0));
    check_val({tag, "_data"},  64'(data_out_m | data_out_l), 64'(0));
    check_val({tag, "_keep"},  64'(keep_out_m | keep_out_l), 64'(0));
    check_val({tag, "_last"},  64'(last_out_m | last_out_l), 64'(0));
  endtask

  // consumer ready: normally high, one scripted 3-cycle stall, or random in the soak phase
  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bp_arm && valid_out_m) begin
        bp_arm    = 1'b0;
        ready_out = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        ready_out = 1'b1;
      end else if (rand_bp) begin
        ready_out = ($urandom_range(0, 3) != 0);
      end else begin
        ready_out = 1'b1;
      end
    end
  end

  // output monitor
  initial begin
    logic [E_W-1:0] g_m, g_l, hw_m, hw_l;
    bit hold_m, hold_l;
    hold_m = 1'b0;
    hold_l = 1'b0;
    hw_m   = '0;
    hw_l   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        g_m = {last_out_m, keep_out_m, data_out_m};
        g_l = {last_out_l, keep_out_l, data_out_l};
        if (valid_out_m && ready_out) begin
          if (exp_q_m.size() == 0) check_val("msb_unexpected_word", 64'(1), 64'(0));
          else cmp_word("msb", g_m, exp_q_m.pop_front());
          hold_m = 1'b0;
        end else if (valid_out_m) begin
          if (hold_m) check_val("msb_hold", 64'(g_m), 64'(hw_m));
          check_val("msb_ready_in_stall", 64'(ready_in_m), 64'(0));
          hold_m = 1'b1;
          hw_m   = g_m;
        end else begin
          hold_m = 1'b0;
        end
        if (valid_out_l && ready_out) begin
          if (exp_q_l.size() == 0) check_val("lsb_unexpected_word", 64'(1), 64'(0));
          else cmp_word("lsb", g_l, exp_q_l.pop_front());
          hold_l = 1'b0;
        end else if (valid_out_l) begin
          if (hold_l) check_val("lsb_hold", 64'(g_l), 64'(hw_l));
          check_val("lsb_ready_in_stall", 64'(ready_in_l), 64'(0));
          hold_l = 1'b1;
          hw_l   = g_l;
        end else begin
          hold_l = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // main sequence
  initial begin
    int waited;
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    last_in  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check_val("reset_ready_in", 64'(ready_in_m), 64'(1));
    rst = 1'b0;

    // full word, back-to-back beats
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b0);
    idle(3);

    // partial flush, then next packet must restart in the first lane
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    idle(2);
    send_beat(8'h5A, 1'b0);
    send_beat(8'h6B, 1'b0);
    send_beat(8'h7C, 1'b0);
    send_beat(8'h8D, 1'b1);
    idle(2);

    // last on the first beat
    send_beat(8'hE1, 1'b1);
    idle(2);

    // streaming with a 3-cycle consumer stall on the first word
    bp_arm = 1'b1;
    for (int i = 1; i <= 12; i++) send_beat(IN_W'(i), 1'b0);
    idle(6);
    check_val("stall_applied", 64'(bp_arm), 64'(0));

    // gapped input
    send_beat(8'h10, 1'b0); idle(2);
    send_beat(8'h20, 1'b0); idle(2);
    send_beat(8'h30, 1'b0); idle(2);
    send_beat(8'h40, 1'b0);
    idle(3);

    // reset with a partial word in flight
    send_beat(8'h55, 1'b0);
    send_beat(8'h66, 1'b0);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0;
    model_reset();
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b0);
    send_beat(8'h04, 1'b0);
    idle(3);

    // random soak with random consumer stalls
    rand_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send_beat(IN_W'($urandom), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
    rand_bp = 1'b0;

    waited = 0;
    while ((exp_q_m.size() != 0 || exp_q_l.size() != 0) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    idle(3);
    check_val("drain_msb", 64'(exp_q_m.size()), 64'(0));
    check_val("drain_lsb", 64'(exp_q_l.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
